mem_arbiter: RTL

//  Shares the single multi-cycle main memory between the I-cache and the D-cache miss paths.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arb_if.sv | 47 ++++
 rtl/mem_arb_perf.sv | 31 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the I/D memory arbiter.
//   Sizing  : ADDR_W, DATA_W, WORDS_PER_BLOCK, IDX_W (fill index), CNT_W (issue/return counters)
//   Types   : state_e (IDLE/FILL/WRITE/DONE), owner_e (I/D)
//   Helper  : block_base() aligns a byte address to its block
package mem_arb_pkg;

    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam int unsigned IDX_W           = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned CNT_W           = IDX_W + 1;
    localparam int unsigned PERF_W          = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Blocks hold 2-byte words, so the block spans 2*WORDS_PER_BLOCK bytes.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of cache-miss requests, memory port, fill port and stall outputs.
//   master : arbiter side (drives memory strobes, fill port, done pulses, stalls)
//   slave  : cache/memory side (drives requests and read returns)
interface mem_arb_if;
    import mem_arb_pkg::*;

    logic              i_miss_req;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss_req;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [DATA_W-1:0] d_wr_data;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    logic              fill_we_i;
    logic              fill_we_d;
    logic [IDX_W-1:0]  fill_idx;
    logic [DATA_W-1:0] fill_data;
    logic              i_done;
    logic              d_done;
    logic              stall_fetch;
    logic              stall_mem;

    modport master (
        input  i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
        input  d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_rvalid,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_we_i, fill_we_d, fill_idx, fill_data,
        output i_done, d_done, stall_fetch, stall_mem
    );

    modport slave (
        output i_miss_req, i_miss_addr, d_miss_req, d_miss_addr,
        output d_wr_req, d_wr_addr, d_wr_data, mem_rdata, mem_rvalid,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_we_i, fill_we_d, fill_idx, fill_data,
        input  i_done, d_done, stall_fetch, stall_mem
    );

endinterface

// File: rtl/mem_arb_perf.sv
// Saturating performance counters: I grants, D miss grants, stall_fetch cycles.
//   clk, rst           : clock, synchronous active-high clear
//   grant_i, grant_d   : one-cycle grant strobes
//   stall              : stall_fetch level
//   perf_i_miss/perf_d_miss/perf_stall : counter values
module mem_arb_perf
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              grant_i,
    input  logic              grant_d,
    input  logic              stall,
    output logic [PERF_W-1:0] perf_i_miss,
    output logic [PERF_W-1:0] perf_d_miss,
    output logic [PERF_W-1:0] perf_stall
);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_i_miss <= '0;
            perf_d_miss <= '0;
            perf_stall  <= '0;
        end else begin
            if (grant_i && (perf_i_miss != '1)) perf_i_miss <= perf_i_miss + PERF_W'(1);
            if (grant_d && (perf_d_miss != '1)) perf_d_miss <= perf_d_miss + PERF_W'(1);
            if (stall   && (perf_stall  != '1)) perf_stall  <= perf_stall  + PERF_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates main memory between I-cache fills, D-cache fills and write-through stores,
// drives the fill port of the owning cache, and produces pipeline stalls.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arb_if.master (requests, memory port, fill port, done pulses, stalls)
//   perf_*   : saturating counters, present only with MEM_ARB_PERF_CNT_EN defined
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mem_arb_if.master  bus
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_i_miss,
    output logic [PERF_W-1:0] perf_d_miss,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    state_e             state, state_nxt;
    owner_e             owner, owner_nxt;
    logic [ADDR_W-1:0]  base, base_nxt;
    logic [CNT_W-1:0]   issue_cnt, issue_nxt;
    logic [CNT_W-1:0]   ret_cnt, ret_nxt;

    // State and transaction context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_I;
            base      <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            base      <= base_nxt;
            issue_cnt <= issue_nxt;
            ret_cnt   <= ret_nxt;
        end
    end

    // Next state and outputs; everything is forced low while rst is held
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        base_nxt      = base;
        issue_nxt     = issue_cnt;
        ret_nxt       = ret_cnt;
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.fill_we_i = 1'b0;
        bus.fill_we_d = 1'b0;
        bus.fill_idx  = '0;
        bus.fill_data = '0;
        bus.i_done    = 1'b0;
        bus.d_done    = 1'b0;

        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    issue_nxt = '0;
                    ret_nxt   = '0;
                    if (bus.d_wr_req) begin
                        owner_nxt = OWN_D;
                        state_nxt = ST_WRITE;
                    end else if (bus.d_miss_req) begin
                        owner_nxt = OWN_D;
                        base_nxt  = block_base(bus.d_miss_addr);
                        state_nxt = ST_FILL;
                    end else if (bus.i_miss_req) begin
                        owner_nxt = OWN_I;
                        base_nxt  = block_base(bus.i_miss_addr);
                        state_nxt = ST_FILL;
                    end
                end
                ST_WRITE: begin
                    bus.mem_en    = 1'b1;
                    bus.mem_wr    = 1'b1;
                    bus.mem_addr  = bus.d_wr_addr;
                    bus.mem_wdata = bus.d_wr_data;
                    state_nxt     = ST_DONE;
                end
                ST_FILL: begin
                    // Issue and return run independently; returns arrive in issue order
                    if (issue_cnt < CNT_W'(WORDS_PER_BLOCK)) begin
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = base + (ADDR_W'(issue_cnt) << 1);
                        issue_nxt    = issue_cnt + CNT_W'(1);
                    end
                    if (bus.mem_rvalid) begin
                        bus.fill_we_i = (owner == OWN_I);
                        bus.fill_we_d = (owner == OWN_D);
                        bus.fill_idx  = IDX_W'(ret_cnt);
                        bus.fill_data = bus.mem_rdata;
                        ret_nxt       = ret_cnt + CNT_W'(1);
                        if (ret_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    bus.i_done = (owner == OWN_I);
                    bus.d_done = (owner == OWN_D);
                    state_nxt  = ST_IDLE;
                end
            endcase
        end
    end

    // Stalls follow the requests directly so the pipeline freezes in the request cycle
    assign bus.stall_mem   = !rst && (bus.d_miss_req || bus.d_wr_req) && !bus.d_done;
    assign bus.stall_fetch = !rst && (bus.stall_mem || (bus.i_miss_req && !bus.i_done));

`ifdef MEM_ARB_PERF_CNT_EN
    logic grant_i_c;
    logic grant_d_c;

    // Only fills count as miss grants; stores do not
    assign grant_i_c = (state == ST_IDLE) && (state_nxt == ST_FILL) && (owner_nxt == OWN_I);
    assign grant_d_c = (state == ST_IDLE) && (state_nxt == ST_FILL) && (owner_nxt == OWN_D);

    mem_arb_perf u_perf (
        .clk         (clk),
        .rst         (rst),
        .grant_i     (grant_i_c),
        .grant_d     (grant_d_c),
        .stall       (bus.stall_fetch),
        .perf_i_miss (perf_i_miss),
        .perf_d_miss (perf_d_miss),
        .perf_stall  (perf_stall)
    );
`endif

endmodule
